// File: rtl/fwd_hazard_ctrl.sv
// Purpose: operand-forward select generation and load-use / flush / memory-busy hazard control for a 5-stage core.
// Latency: m1sel/m2sel registered on the advance that moves an instruction into EX; stall/bubble/freeze combinational.
// Backpressure: mem_busy freezes every tracked slot, the selects and the counter; stall_if_id holds fetch meanwhile.
//
// Ports:
//   clk, rst                  pipeline clock, synchronous active-high reset
//   id_valid, id_rs1/2,
//   id_uses_rs1/2, id_rd,
//   id_regwrite, id_memread   decoded fields of the instruction currently in ID
//   flush                     taken branch/jump in EX, squash the ID instruction
//   mem_busy                  data memory not ready, hold the whole pipe
//   m1sel, m2sel              EX operand mux selects: 00 reg/PC, 01 WB data, 10 MEM ALU result
//   stall_if_id, bubble_ex,
//   freeze                    pipeline control strobes for the current cycle
//   stall_count               saturating count of load-use bubbles since reset
module fwd_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  input  logic        mem_busy,
  output logic [1:0]  m1sel,
  output logic [1:0]  m2sel,
  output logic        stall_if_id,
  output logic        bubble_ex,
  output logic        freeze,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       regwrite;
  } slot_t;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // The instruction leaving MEM is only of interest while it is in WB, and the
  // register file is write-through, so the WB occupant never feeds a select:
  // no WB shadow is kept. Only the EX occupant needs its load flag.
  slot_t ex_slot;
  slot_t mem_slot;
  logic  ex_memread;
  logic  pending_flush;

  logic  eff_flush;
  logic  load_use;
  logic  issue;
  logic [1:0] sel1;
  logic [1:0] sel2;

  function automatic logic slot_writes(input slot_t s, input logic [4:0] r);
    return s.vld && s.regwrite && (s.rd == r) && (r != 5'd0);
  endfunction

  // Select for an operand of the instruction about to enter EX. The current EX
  // occupant will be in MEM next cycle (ALU result forwardable unless it is a
  // load); the current MEM occupant will be in WB. Nearer producer wins.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] rs,
                                         input slot_t ex_s, input logic ex_ld,
                                         input slot_t mem_s);
    if (uses && slot_writes(ex_s, rs) && !ex_ld)
      return SEL_MEM;
    else if (uses && slot_writes(mem_s, rs))
      return SEL_WB;
    else
      return SEL_REG;
  endfunction

  assign eff_flush = flush | pending_flush;

  assign load_use = id_valid && ex_slot.vld && ex_memread && (ex_slot.rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_slot.rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_slot.rd)));

  // ID instruction actually moves into EX on this advance.
  assign issue = id_valid && !load_use && !eff_flush;

  assign sel1 = fwd_sel(id_uses_rs1, id_rs1, ex_slot, ex_memread, mem_slot);
  assign sel2 = fwd_sel(id_uses_rs2, id_rs2, ex_slot, ex_memread, mem_slot);

  // Strobes are gated by rst so the surrounding pipe sees a quiet control
  // interface while it is being reset.
  assign freeze      = !rst && mem_busy;
  assign stall_if_id = !rst && (mem_busy || (load_use && !eff_flush));
  assign bubble_ex   = !rst && !mem_busy && (load_use || eff_flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot       <= '0;
      mem_slot      <= '0;
      ex_memread    <= 1'b0;
      pending_flush <= 1'b0;
      m1sel         <= SEL_REG;
      m2sel         <= SEL_REG;
      stall_count   <= 16'd0;
    end else if (mem_busy) begin
      // A flush arriving mid-freeze must not be lost: remember it until the
      // first cycle the pipe advances again.
      if (flush)
        pending_flush <= 1'b1;
    end else begin
      pending_flush <= 1'b0;
      mem_slot      <= ex_slot;
      if (issue) begin
        ex_slot.vld      <= 1'b1;
        ex_slot.rd       <= id_rd;
        ex_slot.regwrite <= id_regwrite;
        ex_memread       <= id_memread;
        m1sel            <= sel1;
        m2sel            <= sel2;
      end else begin
        ex_slot    <= '0;
        ex_memread <= 1'b0;
        m1sel      <= SEL_REG;
        m2sel      <= SEL_REG;
      end
      if (load_use && !eff_flush && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Purpose: self-checking bench for fwd_hazard_ctrl driven from a vector table plus a counter-saturation run.
// Latency: strobes checked mid-cycle after driving; registered selects/counter checked just after the next rising edge.
// Backpressure: mem_busy windows are part of the vector table; expected register values travel through a queue.
module tb_fwd_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;
  logic        mem_busy;
  logic [1:0]  m1sel;
  logic [1:0]  m2sel;
  logic        stall_if_id;
  logic        bubble_ex;
  logic        freeze;
  logic [15:0] stall_count;

  fwd_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .mem_busy    (mem_busy),
    .m1sel       (m1sel),
    .m2sel       (m2sel),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex),
    .freeze      (freeze),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        fl;
    logic        mb;
    logic [2:0]  sbf;   // expected {stall_if_id, bubble_ex, freeze} this cycle
    logic [1:0]  m1;    // expected m1sel after the edge
    logic [1:0]  m2;    // expected m2sel after the edge
    logic [15:0] cnt;   // expected stall_count after the edge
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  m1;
    logic [1:0]  m2;
    logic [15:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t ins(string nm, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                               logic [4:0] rd, logic rw, logic mr, logic fl, logic mb,
                               logic [2:0] sbf, logic [1:0] m1, logic [1:0] m2, logic [15:0] cnt);
    vec_t t;
    t.name = nm; t.rst = 1'b0; t.vld = 1'b1;
    t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.rw = rw; t.mr = mr; t.fl = fl; t.mb = mb;
    t.sbf = sbf; t.m1 = m1; t.m2 = m2; t.cnt = cnt;
    return t;
  endfunction

  function automatic vec_t nop(string nm, logic [15:0] cnt);
    vec_t t;
    t = ins(nm, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, cnt);
    t.vld = 1'b0;
    return t;
  endfunction

  // Reset cycle with a would-be hazard reader in ID and busy/flush raised:
  // all strobes must stay low and all state must clear.
  function automatic vec_t rst_vec(string nm, logic fl, logic mb);
    vec_t t;
    t = ins(nm, 5'd7, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0, fl, mb, 3'b000, 2'b00, 2'b00, 16'd0);
    t.rst = 1'b1;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    exp_t e;
    @(negedge clk);
    rst = t.rst; id_valid = t.vld;
    id_rs1 = t.rs1; id_uses_rs1 = t.u1; id_rs2 = t.rs2; id_uses_rs2 = t.u2;
    id_rd = t.rd; id_regwrite = t.rw; id_memread = t.mr;
    flush = t.fl; mem_busy = t.mb;
    #1;
    chk({t.name, ".stall_if_id"}, {15'd0, stall_if_id}, {15'd0, t.sbf[2]});
    chk({t.name, ".bubble_ex"},   {15'd0, bubble_ex},   {15'd0, t.sbf[1]});
    chk({t.name, ".freeze"},      {15'd0, freeze},      {15'd0, t.sbf[0]});
    e.name = t.name; e.m1 = t.m1; e.m2 = t.m2; e.cnt = t.cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.name, ".m1sel"},       {14'd0, m1sel}, {14'd0, e.m1});
    chk({e.name, ".m2sel"},       {14'd0, m2sel}, {14'd0, e.m2});
    chk({e.name, ".stall_count"}, stall_count,    e.cnt);
    n_vec++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0; id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;
    flush = 1'b0; mem_busy = 1'b0;

    //            name           rs1  u1  rs2  u2  rd  rw mr fl mb  {s,b,f}  m1     m2     cnt
    tbl.push_back(rst_vec("rst0", 1'b1, 1'b1));
    tbl.push_back(rst_vec("rst1", 1'b0, 1'b1));
    // ALU producer directly followed by consumer on rs1: MEM-stage forward.
    tbl.push_back(ins("a_add",   1, 1, 2, 1,  5, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0));
    tbl.push_back(ins("a_sub",   5, 1, 6, 1,  8, 1, 0, 0, 0, 3'b000, 2'b10, 2'b00, 0));
    tbl.push_back(nop("a_n1", 0));
    tbl.push_back(nop("a_n2", 0));
    // One instruction gap: WB forward on rs2.
    tbl.push_back(ins("b_add",   1, 1, 2, 1,  5, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0));
    tbl.push_back(nop("b_gap", 0));
    tbl.push_back(ins("b_or",    3, 1, 5, 1,  9, 1, 0, 0, 0, 3'b000, 2'b00, 2'b01, 0));
    tbl.push_back(nop("b_n1", 0));
    tbl.push_back(nop("b_n2", 0));
    // Two producers of x5: the nearer one (MEM) must win.
    tbl.push_back(ins("p_add1",  1, 1, 2, 1,  5, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0));
    tbl.push_back(ins("p_add2",  3, 1, 4, 1,  5, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0));
    tbl.push_back(ins("p_use",   5, 1, 5, 1, 10, 1, 0, 0, 0, 3'b000, 2'b10, 2'b10, 0));
    tbl.push_back(nop("p_n1", 0));
    tbl.push_back(nop("p_n2", 0));
    // Load-use: one stall/bubble cycle, consumer then forwards from WB.
    tbl.push_back(ins("c_lw",    2, 1, 0, 0,  7, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0));
    tbl.push_back(ins("c_stall", 7, 1, 3, 1, 11, 1, 0, 0, 0, 3'b110, 2'b00, 2'b00, 1));
    tbl.push_back(ins("c_go",    7, 1, 3, 1, 11, 1, 0, 0, 0, 3'b000, 2'b01, 2'b00, 1));
    tbl.push_back(nop("c_n1", 1));
    tbl.push_back(nop("c_n2", 1));
    // x0 never forwards or stalls; unused operands never forward or stall.
    tbl.push_back(ins("d_add_x0",1, 1, 2, 1,  0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("d_rd_x0", 0, 1, 0, 1, 12, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("d_lw_x0", 2, 1, 0, 0,  0, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("d_rd_x0b",0, 1, 0, 1, 12, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("d_add_x4",1, 1, 2, 1,  4, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("d_auipc", 4, 0, 4, 0, 13, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("d_lw_x6", 1, 1, 0, 0,  6, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("d_jal",   6, 0, 6, 0,  1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(nop("d_n1", 1));
    tbl.push_back(nop("d_n2", 1));
    // Three-cycle freeze with SUB (forwarded from MEM) resident in EX.
    tbl.push_back(ins("e_add",   1, 1, 2, 1,  5, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("e_sub",   5, 1, 3, 1, 14, 1, 0, 0, 0, 3'b000, 2'b10, 2'b00, 1));
    tbl.push_back(ins("e_frz0",  3, 1, 5, 1, 15, 1, 0, 0, 1, 3'b101, 2'b10, 2'b00, 1));
    tbl.push_back(ins("e_frz1",  3, 1, 5, 1, 15, 1, 0, 0, 1, 3'b101, 2'b10, 2'b00, 1));
    tbl.push_back(ins("e_frz2",  3, 1, 5, 1, 15, 1, 0, 0, 1, 3'b101, 2'b10, 2'b00, 1));
    tbl.push_back(ins("e_or",    3, 1, 5, 1, 15, 1, 0, 0, 0, 3'b000, 2'b00, 2'b01, 1));
    tbl.push_back(nop("e_n1", 1));
    tbl.push_back(nop("e_n2", 1));
    // Flush overrides a load-use hazard outright.
    tbl.push_back(ins("f_lw",    2, 1, 0, 0,  7, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("f_flush", 7, 1, 3, 1, 11, 1, 0, 1, 0, 3'b010, 2'b00, 2'b00, 1));
    tbl.push_back(ins("f_next",  7, 1, 7, 1, 20, 1, 0, 0, 0, 3'b000, 2'b01, 2'b01, 1));
    tbl.push_back(nop("f_n1", 1));
    tbl.push_back(nop("f_n2", 1));
    // Flush during freeze with load-use pending: applied on first unfrozen cycle.
    tbl.push_back(ins("g_lw",    2, 1, 0, 0,  7, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("g_frz",   7, 1, 3, 1, 11, 1, 0, 0, 1, 3'b101, 2'b00, 2'b00, 1));
    tbl.push_back(ins("g_frz_fl",7, 1, 3, 1, 11, 1, 0, 1, 1, 3'b101, 2'b00, 2'b00, 1));
    tbl.push_back(ins("g_unfrz", 7, 1, 3, 1, 11, 1, 0, 0, 0, 3'b010, 2'b00, 2'b00, 1));
    tbl.push_back(ins("g_after", 7, 1, 7, 1, 20, 1, 0, 0, 0, 3'b000, 2'b01, 2'b01, 1));
    tbl.push_back(nop("g_n1", 1));
    tbl.push_back(nop("g_n2", 1));
    // Reset while frozen with a pending flush and a load in EX discards everything.
    tbl.push_back(ins("h_lw",    2, 1, 0, 0,  7, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 1));
    tbl.push_back(ins("h_frz_fl",7, 1, 3, 1, 11, 1, 0, 1, 1, 3'b101, 2'b00, 2'b00, 1));
    tbl.push_back(rst_vec("h_rst", 1'b0, 1'b1));
    tbl.push_back(ins("h_post",  7, 1, 3, 1, 11, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Saturation: a load that reads its own destination, held in ID, hazards
    // on every second edge (edge k leaves floor(k/2) bubbles counted).
    run_vec(rst_vec("s_rst", 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0; id_valid = 1'b1; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    id_rs2 = 5'd0; id_uses_rs2 = 1'b0; id_rd = 5'd7; id_regwrite = 1'b1;
    id_memread = 1'b1; flush = 1'b0; mem_busy = 1'b0;
    for (int k = 1; k <= 140000; k++) begin
      @(posedge clk);
      #1;
      if (k == 131068) begin
        chk("sat_fffe", stall_count, 16'hFFFE);
        n_vec++;
      end
      if (k == 131070) begin
        chk("sat_ffff", stall_count, 16'hFFFF);
        n_vec++;
      end
      if (k == 139999) begin
        chk("sat_stall", {15'd0, stall_if_id}, 16'd1);
        chk("sat_bubble", {15'd0, bubble_ex}, 16'd1);
        n_vec++;
      end
    end
    chk("sat_hold", stall_count, 16'hFFFF);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
